// File: rtl/regset_bus_arbiter_if.sv
// Bus-arbitration bundle between the regset read-port arbiter and its requesters.
// The arbiter side uses the master modport. The requester/regset side uses the slave modport.
interface regset_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] i_regSel;
  logic [NUM_REQ-1:0] o_gnt;
  logic [ID_W-1:0]    o_gntId;
  logic               o_busSel;
  logic               o_nBusEn;
  logic               o_busy;

  modport master (
    input  i_req, i_regSel,
    output o_gnt, o_gntId, o_busSel, o_nBusEn, o_busy
  );

  modport slave (
    output i_req, i_regSel,
    input  o_gnt, o_gntId, o_busSel, o_nBusEn, o_busy
  );
endinterface

// File: rtl/regset_bus_arbiter.sv
// Round-robin arbiter for the regset tri-state read bus, with bounded grant tenure.
// Define REGSET_ARB_TURNAROUND_EN to insert one dead bus cycle (TURN) on every owner release.
module regset_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  regset_bus_arbiter_if.master bus
);
  localparam int          ID_W      = $clog2(NUM_REQ);
  localparam int unsigned NREQ_U    = NUM_REQ;
  localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [7:0]         hold_q, hold_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    win_next;
  logic               others_req;
  logic               release_gnt;

  // The winner is the first requester at or above rr_q, wrapping around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = (32'(rr_q) + k) % NREQ_U;
      if (!win_found && bus.i_req[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
    win_next   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    others_req = |(bus.i_req & ~gnt_q);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    release_gnt = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        gnt_d  = '0;
        id_d   = '0;
        hold_d = '0;
        if (win_found) begin
          state_d        = GRANT;
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          rr_d           = win_next;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + 8'd1;
        release_gnt = !bus.i_req[id_q] || ((hold_q == HOLD_LAST) && others_req);
        if (release_gnt) begin
          gnt_d  = '0;
          id_d   = '0;
          hold_d = '0;
`ifdef REGSET_ARB_TURNAROUND_EN
          state_d = TURN;
`else
          // Direct handover: arbitrate in the release cycle so the bus never goes idle.
          if (win_found) begin
            state_d       = GRANT;
            gnt_d[win_id] = 1'b1;
            id_d          = win_id;
            rr_d          = win_next;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.o_gnt    = gnt_q;
  assign bus.o_gntId  = id_q;
  assign bus.o_busSel = (|gnt_q) ? bus.i_regSel[id_q] : 1'b0;
  assign bus.o_nBusEn = ~(|gnt_q);
  assign bus.o_busy   = (state_q != IDLE);

endmodule
